// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl_pkg
// Description : Shared types and defaults for the pipeline stall controller.
// Revision    : 1.0  - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

    // Controller states: normal flow, data-cache wait, fetch wait, halted.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Default number of cycles a single cache wait may last before the
    // timeout flag is raised.
    localparam int WAIT_LIMIT_DEFAULT = 1024;

endpackage : pipeline_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl_sat_counter
// Description : Saturating up-counter with synchronous clear. Used for the
//               stall cycle count and for the cache-wait timer.
// Revision    : 1.0  - initial release
// ============================================================================
module pipeline_stall_ctrl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment; the count holds once it reaches max.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : pipeline_stall_ctrl_sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Five-stage pipeline hazard/stall controller. Decodes cache
//               misses, load-use hazards, taken branches and halt into
//               per-buffer locks, IF/ID flush and ID/EX bubble.
// Revision    : 1.0  - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             load_use_hazard,
    input  logic             branch_taken_ex,
    input  logic             halted_controller_wb,
    output logic             lock_pc,
    output logic             lock_if_id,
    output logic             lock_id_ex,
    output logic             lock_ex_mem,
    output logic             lock_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    // Timer wide enough to reach WAIT_LIMIT itself (where it saturates).
    localparam int TMR_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(WAIT_LIMIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_lock_all;
    logic             w_lock_front;
    logic             w_flush;
    logic             w_bubble;
    logic             w_in_wait;
    logic             w_tmr_clr;
    logic             w_tmr_inc;
    logic [TMR_W-1:0] w_timer;
    logic             r_timeout;

    // State register; reset returns to RUN regardless of the current wait.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode. w_lock_all locks every buffer;
    // w_lock_front locks only PC and IF/ID (the ID/EX bubble is separate).
    always_comb begin
        w_next_state = r_state;
        w_lock_all   = 1'b0;
        w_lock_front = 1'b0;
        w_flush      = 1'b0;
        w_bubble     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (halted_controller_wb) begin
                    w_lock_all   = 1'b1;
                    w_next_state = ST_HALT;
                end else if (dcache_miss) begin
                    w_lock_all   = 1'b1;
                    w_next_state = ST_DWAIT;
                end else if (icache_miss) begin
                    w_lock_front = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = ST_IWAIT;
                end else if (load_use_hazard) begin
                    w_lock_front = 1'b1;
                    w_bubble     = 1'b1;
                end else if (branch_taken_ex) begin
                    w_flush      = 1'b1;
                    w_bubble     = 1'b1;
                end
            end
            ST_DWAIT: begin
                // Branch pulses are ignored here: EX/MEM is frozen, so EX
                // presents the branch again once the miss is serviced.
                if (halted_controller_wb) begin
                    w_lock_all   = 1'b1;
                    w_next_state = ST_HALT;
                end else if (dcache_ready) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_lock_all   = 1'b1;
                end
            end
            ST_IWAIT: begin
                // A data miss overrides the fetch wait; icache_miss is a held
                // level and is looked at again in RUN afterwards.
                if (halted_controller_wb) begin
                    w_lock_all   = 1'b1;
                    w_next_state = ST_HALT;
                end else if (dcache_miss) begin
                    w_lock_all   = 1'b1;
                    w_next_state = ST_DWAIT;
                end else if (icache_ready) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_lock_front = 1'b1;
                    w_bubble     = 1'b1;
                end
            end
            ST_HALT: begin
                w_lock_all = 1'b1;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    assign lock_pc      = w_lock_all | w_lock_front;
    assign lock_if_id   = w_lock_all | w_lock_front;
    assign lock_id_ex   = w_lock_all;
    assign lock_ex_mem  = w_lock_all;
    assign lock_mem_wb  = w_lock_all;
    // Flush/bubble are only ever decoded on paths where w_lock_all is 0.
    assign flush_if_id  = w_flush;
    assign bubble_id_ex = w_bubble;
    assign halted       = (r_state == ST_HALT);

    // Wait timer control: clear when entering a wait state (including the
    // IWAIT -> DWAIT hand-over), count each cycle the wait continues.
    assign w_in_wait = (r_state == ST_DWAIT) || (r_state == ST_IWAIT);
    assign w_tmr_clr = ((w_next_state == ST_DWAIT) || (w_next_state == ST_IWAIT))
                       && (w_next_state != r_state);
    assign w_tmr_inc = w_in_wait && (w_next_state == r_state);

    pipeline_stall_ctrl_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst_b),
        .inc   (lock_pc),
        .clr   (1'b0),
        .max   (STALL_MAX),
        .count (stall_count)
    );

    pipeline_stall_ctrl_sat_counter #(
        .WIDTH (TMR_W)
    ) u_wait_tmr (
        .clk   (clk),
        .rst   (rst_b),
        .inc   (w_tmr_inc),
        .clr   (w_tmr_clr),
        .max   (TMR_MAX),
        .count (w_timer)
    );

    // Sticky timeout: set on the edge where the timer reaches WAIT_LIMIT.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_timeout <= 1'b0;
        end else if (w_tmr_inc && (w_timer == TMR_LAST)) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_err = r_timeout;

endmodule : pipeline_stall_ctrl
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed self-checking bench. Two instances share stimulus:
//               one with default parameters, one small (CNT_W=3,
//               WAIT_LIMIT=4) for saturation and timeout.
// Revision    : 1.0  - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam logic [6:0] ALL    = 7'b11111_00;
    localparam logic [6:0] NONE   = 7'b00000_00;
    localparam logic [6:0] ISTALL = 7'b11000_01;
    localparam logic [6:0] BR     = 7'b00000_11;

    logic clk = 1'b0;
    logic rst_b, dm, dr, im, ir, luh, br, hw;

    logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_flush, b_bub, b_halt, b_tmo;
    logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_bub, s_halt, s_tmo;
    logic [15:0] b_cnt;
    logic [2:0]  s_cnt;
    logic [6:0]  bvec, svec;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    assign bvec = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_flush, b_bub};
    assign svec = {s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_bub};

    always #5 clk = ~clk;

    pipeline_stall_ctrl u_big (
        .clk(clk), .rst_b(rst_b),
        .dcache_miss(dm), .dcache_ready(dr), .icache_miss(im), .icache_ready(ir),
        .load_use_hazard(luh), .branch_taken_ex(br), .halted_controller_wb(hw),
        .lock_pc(b_pc), .lock_if_id(b_ifid), .lock_id_ex(b_idex),
        .lock_ex_mem(b_exmem), .lock_mem_wb(b_memwb), .flush_if_id(b_flush),
        .bubble_id_ex(b_bub), .halted(b_halt), .timeout_err(b_tmo),
        .stall_count(b_cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(3), .WAIT_LIMIT(4)) u_small (
        .clk(clk), .rst_b(rst_b),
        .dcache_miss(dm), .dcache_ready(dr), .icache_miss(im), .icache_ready(ir),
        .load_use_hazard(luh), .branch_taken_ex(br), .halted_controller_wb(hw),
        .lock_pc(s_pc), .lock_if_id(s_ifid), .lock_id_ex(s_idex),
        .lock_ex_mem(s_exmem), .lock_mem_wb(s_memwb), .flush_if_id(s_flush),
        .bubble_id_ex(s_bub), .halted(s_halt), .timeout_err(s_tmo),
        .stall_count(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dm = 0; dr = 0; im = 0; ir = 0; luh = 0; br = 0; hw = 0;
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst_b = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Reset state ----
        do_reset();
        chk("reset_outputs", bvec, NONE);
        chk("reset_count",   b_cnt, 0);
        chk("reset_halted",  b_halt, 0);
        chk("reset_timeout", b_tmo, 0);

        // ---- D-miss: cycles 5..11 locked, ready in cycle 12 ----
        repeat (4) tick();
        dm = 1; #1;
        chk("dmiss_entry", bvec, ALL);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("dwait_locks", bvec, ALL);
            if (i == 4) chk("small_tmo_before", s_tmo, 0);
            if (i == 5) begin
                chk("small_tmo_set",   s_tmo, 1);
                chk("small_tmo_locks", svec, ALL);
            end
        end
        tick();
        dr = 1; #1;
        chk("dready_release", bvec, NONE);
        tick();
        dr = 0; dm = 0; #1;
        chk("dmiss_after", bvec, NONE);
        chk("dmiss_count", b_cnt, 7);
        chk("big_no_timeout", b_tmo, 0);

        // ---- I-miss: front locks + bubble for 5 cycles ----
        do_reset();
        repeat (2) tick();
        im = 1; #1;
        chk("imiss_entry", bvec, ISTALL);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("iwait_decode", bvec, ISTALL);
            chk("iwait_memwb",  b_memwb, 0);
        end
        tick();
        ir = 1; #1;
        chk("iready_release", bvec, NONE);
        tick();
        ir = 0; im = 0; #1;
        chk("imiss_after", bvec, NONE);
        chk("imiss_count", b_cnt, 5);

        // ---- Load-use then branch in RUN ----
        luh = 1; #1;
        chk("load_use", bvec, ISTALL);
        tick();
        luh = 0; br = 1; #1;
        chk("branch_flush", bvec, BR);
        tick();
        br = 0; #1;
        chk("idle_after_branch", bvec, NONE);
        chk("luh_count", b_cnt, 6);

        // ---- Simultaneous events ----
        im = 1; luh = 1; br = 1; #1;
        chk("simul_priority", bvec, ISTALL);
        tick();
        luh = 0; br = 0; #1;
        chk("simul_iwait", bvec, ISTALL);
        dm = 1; #1;
        chk("dmiss_in_iwait", bvec, ALL);
        tick();
        br = 1; #1;
        chk("branch_ignored_dwait", bvec, ALL);
        tick();
        br = 0; dm = 0; dr = 1; #1;
        chk("dready_from_iwait", bvec, NONE);
        tick();
        dr = 0; #1;
        chk("imiss_reevaluated", bvec, ISTALL);
        tick();
        ir = 1; #1;
        chk("iready_second", bvec, NONE);
        tick();
        ir = 0; im = 0; #1;
        chk("simul_idle", bvec, NONE);

        // ---- Halt, input toggling, saturation, then reset ----
        do_reset();
        hw = 1; #1;
        chk("halt_entry", bvec, ALL);
        tick();
        hw = 0; #1;
        chk("halted_flag", b_halt, 1);
        chk("halt_locks",  bvec, ALL);
        for (int i = 1; i <= 8; i++) begin
            tick();
            dm = i[0]; dr = i[1]; im = i[2]; ir = ~i[0]; luh = i[1]; br = 1'b1;
            #1;
            chk("halt_toggle_locks", bvec, ALL);
            chk("halt_toggle_flag",  b_halt, 1);
        end
        tick();
        clear_inputs(); #1;
        chk("halt_count_big",   b_cnt, 10);
        chk("halt_count_small", s_cnt, 7);
        rst_b = 1; #1;
        tick();
        rst_b = 0; #1;
        chk("post_reset_outputs", bvec, NONE);
        chk("post_reset_halted",  b_halt, 0);
        chk("post_reset_count",   b_cnt, 0);
        chk("post_reset_small",   {s_halt, s_tmo, s_cnt}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pipeline_stall_ctrl
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall_count counter.
REQ-002 Parameter WAIT_LIMIT, default 1024: maximum number of cycles spent in one cache-wait before timeout_err is raised.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_b, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Inputs, 1 bit each:
  - dcache_miss: level, MEM-stage miss pending.
  - dcache_ready: pulse, miss serviced.
  - icache_miss: level, fetch miss pending.
  - icache_ready: pulse, fetch miss serviced.
  - load_use_hazard: level, from ID.
  - branch_taken_ex: pulse, from EX.
  - halted_controller_wb: halt has reached WB.
REQ-006 Outputs, 1 bit each:
  - lock_pc, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb: 1 = the buffer holds its value.
  - flush_if_id: load a NOP into IF/ID.
  - bubble_id_ex: load zero controls into ID/EX.
  - halted: sticky halt flag.
  - timeout_err: sticky wait-limit error.
REQ-007 Output stall_count, CNT_W bits: saturating count of stalled cycles.

Function
REQ-008 The block SHALL use states RUN, DWAIT, IWAIT and HALT; outputs are a combinational decode of state and inputs, and state is registered.
REQ-009 In RUN, input priority SHALL be: halted_controller_wb > dcache_miss > icache_miss > load_use_hazard > branch_taken_ex.
REQ-010 RUN with dcache_miss=1 SHALL assert all five locks in the same cycle and enter DWAIT at the next edge.
REQ-011 In DWAIT, all locks SHALL stay at 1 while dcache_ready=0.
REQ-012 In the cycle dcache_ready=1, all locks SHALL be 0 and the next state SHALL be RUN.
REQ-013 RUN with icache_miss=1 and dcache_miss=0 SHALL assert lock_pc, lock_if_id and bubble_id_ex, and enter IWAIT; downstream locks stay 0.
REQ-014 In IWAIT, the decode of REQ-013 SHALL hold until icache_ready=1, which returns the block to RUN with no locks asserted in that cycle.
REQ-015 In IWAIT, if dcache_miss=1 the block SHALL go to DWAIT with all locks asserted.
  - icache_miss is a held level and is re-evaluated in RUN after the data miss completes.
REQ-016 load_use_hazard in RUN with no higher-priority input SHALL assert lock_pc, lock_if_id and bubble_id_ex for that cycle only; the state stays RUN.
REQ-017 branch_taken_ex in RUN with no higher-priority input SHALL assert flush_if_id and bubble_id_ex for one cycle; the locks stay 0.
REQ-018 branch_taken_ex SHALL be ignored in DWAIT.
  - EX/MEM is locked in DWAIT, so the branch pulse is re-presented by EX.
REQ-019 halted_controller_wb=1 in any state SHALL assert all locks in that cycle and enter HALT.
REQ-020 In HALT, halted=1 and all locks=1 until reset; every other input is ignored.
REQ-021 stall_count SHALL increment on each edge where lock_pc=1, and saturate at 2^CNT_W-1.
REQ-022 A wait timer SHALL clear on entry to DWAIT or IWAIT and increment each cycle in those states.
  - When the timer reaches WAIT_LIMIT, timeout_err is set; it is sticky and the FSM keeps waiting.
REQ-023 flush_if_id and bubble_id_ex SHALL never be asserted in the same cycle as lock_mem_wb=1.

Reset
REQ-024 While rst_b=1 at an edge, the block SHALL load:
  - state=RUN;
  - stall_count=0, wait timer=0;
  - halted=0, timeout_err=0.
REQ-025 In the cycle after reset, all lock, flush and bubble outputs SHALL be 0 provided all inputs are 0.
REQ-026 Reset asserted during DWAIT, IWAIT or HALT SHALL abort the wait at that edge with no residual locks.

Structure
REQ-027 The state enum typedef and the WAIT_LIMIT default SHALL live in the shared pipeline package.
REQ-028 A sat_counter sub-module (parameterized width, inc, clr, max) SHALL be instantiated twice: stall_count and the wait timer.

Verification
REQ-029 D-miss: dcache_miss=1 at cycle 5, dcache_ready at cycle 12 -> all locks=1 in cycles 5-11, 0 in cycle 12; stall_count=7.
REQ-030 I-miss: icache_miss at cycle 3, ready at cycle 8 -> lock_pc, lock_if_id and bubble_id_ex=1 in cycles 3-7; lock_mem_wb=0 throughout.
REQ-031 Simultaneous events:
  - icache_miss, load_use_hazard and branch_taken_ex all asserted in one RUN cycle -> IWAIT is taken and flush_if_id=0.
  - dcache_miss asserted during IWAIT -> all locks go to 1.
REQ-032 Timeout: WAIT_LIMIT=4, dcache_miss held with no ready -> timeout_err=1 after 4 DWAIT cycles; locks stay 1.
REQ-033 Halt: halted_controller_wb pulse at cycle 20 -> halted=1 from cycle 21; locks stay 1 with all inputs toggling; rst_b at cycle 30 -> RUN and all outputs 0.
REQ-034 Saturation: CNT_W=3 with 10 stalled cycles -> stall_count=7.
